// File: rtl/inst_fetch.sv
// Instruction fetch unit: drives imem_addr from the PC and buffers fetched words in a 2-entry FIFO toward decode.
// Optional FETCH_STATS_EN macro enables the accepted-instruction counter on fetch_count.
module inst_fetch #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready,
  output logic [31:0]       fetch_count
);

  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       inst_mem [2];
  logic [ADDR_W-1:0] pc_mem   [2];
  logic              head_q;
  logic              tail_q;
  logic [1:0]        count_q;
  logic              pop;
  logic              push;

  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_inst  = inst_mem[head_q];
  assign out_pc    = pc_mem[head_q];

  assign pop  = out_valid && out_ready;
  assign push = fetch_en && !redirect_valid && ((count_q != 2'd2) || pop);

  // When the buffer empties, head stays put and tail snaps back to it so the
  // outputs keep showing the last instruction instead of a stale slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      count_q     <= '0;
      inst_mem[0] <= '0;
      inst_mem[1] <= '0;
      pc_mem[0]   <= '0;
      pc_mem[1]   <= '0;
    end else if (redirect_valid) begin
      pc_q    <= redirect_pc;
      count_q <= '0;
      tail_q  <= head_q;
    end else begin
      count_q <= count_q + 2'(push) - 2'(pop);
      if (push) begin
        inst_mem[tail_q] <= imem_inst;
        pc_mem[tail_q]   <= pc_q;
        pc_q             <= pc_q + ADDR_W'(1);
      end
      if (pop && !push && (count_q == 2'd1)) begin
        tail_q <= head_q;
      end else begin
        if (push) tail_q <= ~tail_q;
        if (pop)  head_q <= ~head_q;
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   stat_q <= '0;
    else if (pop) stat_q <= stat_q + 32'd1;
  end

  assign fetch_count = stat_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch; memory model returns word = address + 100.
module tb_inst_fetch;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_inst;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready;
  logic [31:0]       fetch_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  inst_fetch #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  always_comb imem_inst = imem_addr + 32'd100;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  int unsigned exp_cnt [15] = '{0, 1, 2, 2, 3, 3, 4, 5, 5, 5, 6, 7, 8, 9, 10};
  bit          rdy_v   [15] = '{1, 1, 1, 0, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1};

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset values
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_inst", out_inst, 0);
    check("rst_pc", out_pc, 0);
    check("rst_cnt", fetch_count, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Streaming with out_ready held high
    for (int k = 0; k < 4; k++) begin
      step();
      check("str_valid", out_valid, 1);
      check("str_pc", out_pc, k);
      check("str_inst", out_inst, k + 100);
    end

    // Backpressure: fill to 2 and hold
    apply_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("bp_valid", out_valid, 1);
    check("bp_addr", imem_addr, 2);
    check("bp_pc", out_pc, 0);
    check("bp_inst", out_inst, 100);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      check("bp_drain_pc", out_pc, k);
      check("bp_drain_inst", out_inst, k + 100);
    end

    // Redirect at out_pc=5 to 12
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    check("rd_pre_pc", out_pc, 5);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd12;
    step();
    redirect_valid = 1'b0;
    check("rd_gap_valid", out_valid, 0);
    check("rd_gap_addr", imem_addr, 12);
    step();
    check("rd_valid", out_valid, 1);
    check("rd_pc", out_pc, 12);
    check("rd_inst", out_inst, 112);
    step();
    check("rd_next_pc", out_pc, 13);

    // PC wrap from all-ones
    redirect_valid = 1'b1;
    redirect_pc    = '1;
    step();
    redirect_valid = 1'b0;
    check("wr_gap_valid", out_valid, 0);
    step();
    check("wr_pc_max", out_pc, 32'hFFFF_FFFF);
    check("wr_inst_max", out_inst, 99);
    step();
    check("wr_pc_zero", out_pc, 0);
    check("wr_inst_zero", out_inst, 100);

    // fetch_en low: buffer drains, pc holds
    fetch_en = 1'b0;
    step();
    check("fe_valid", out_valid, 0);
    check("fe_addr", imem_addr, 1);
    step();
    check("fe_addr_hold", imem_addr, 1);
    fetch_en = 1'b1;
    step();
    check("fe_resume_pc", out_pc, 1);
    check("fe_resume_valid", out_valid, 1);

    // Asynchronous reset while full
    apply_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("ar_full_valid", out_valid, 1);
    check("ar_full_addr", imem_addr, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_addr", imem_addr, 0);
    #1;
    rst_n = 1'b1;

    // Handshake counter: 10 pops, 3 ready gaps, 1 redirect
    apply_reset();
    for (int k = 0; k < 15; k++) begin
      out_ready      = rdy_v[k];
      redirect_valid = (k == 7);
      redirect_pc    = 32'd20;
      step();
`ifdef FETCH_STATS_EN
      check("stat_cnt", fetch_count, exp_cnt[k]);
`else
      check("stat_cnt_off", fetch_count, 0);
`endif
    end
    redirect_valid = 1'b0;
    check("stat_pc", out_pc, 25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
